// File: rtl/aes_pkg.sv
// Shared AES definitions: sequencer state encoding,
// round constants and the GF(2^8) xtime helper.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_t;

  localparam logic [7:0] AES_RCON_INIT = 8'h01;
  localparam logic [7:0] AES_RCON_POLY = 8'h1B;
  localparam int         AES128_ROUNDS = 10;

  // multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0}
         ^ (b[7] ? AES_RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_controller.sv
// Iterative AES-128 sequencer: owns state/round-key,
// steps external round and key-expansion units.
module aes_round_controller
  import aes_pkg::*;
#(
  parameter int ROUNDS = AES128_ROUNDS
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         key_start,
  input  logic [127:0] plain_in,
  input  logic [127:0] key_in,
  input  logic         hold,
  input  logic         abort,
  output logic [127:0] rnd_state_o,
  output logic [127:0] rnd_key_o,
  output logic [7:0]   rcon_o,
  output logic         final_round_o,
  input  logic [127:0] next_key_i,
  input  logic [127:0] rnd_state_i,
  output logic         busy,
  output logic         transformer_done,
  output logic [127:0] cipher_out,
  output logic         cipher_valid
);

  localparam logic [3:0] LAST = 4'(ROUNDS);

  aes_state_t   st;
  logic [127:0] state_q;
  logic [127:0] key_q;
  logic [3:0]   cnt_q;
  logic [7:0]   rcon_q;
  logic [127:0] cipher_q;
  logic         valid_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      st       <= ST_IDLE;
      state_q  <= '0;
      key_q    <= '0;
      cnt_q    <= '0;
      rcon_q   <= AES_RCON_INIT;
      cipher_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (key_start) begin
            state_q <= plain_in ^ key_in;
            key_q   <= key_in;
            cnt_q   <= 4'd1;
            rcon_q  <= AES_RCON_INIT;
            valid_q <= 1'b0;
            st      <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          if (abort) begin
            cnt_q <= '0;
            st    <= ST_IDLE;
          end else if (!hold) begin
            state_q <= rnd_state_i;
            key_q   <= next_key_i;
            rcon_q  <= xtime(rcon_q);
            cnt_q   <= cnt_q + 4'd1;
            if (cnt_q == LAST) begin
              cipher_q <= rnd_state_i;
              valid_q  <= 1'b1;
              st       <= ST_DONE;
            end
          end
        end
        ST_DONE: st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign rnd_state_o      = state_q;
  assign rnd_key_o        = key_q;
  assign rcon_o           = rcon_q;
  assign cipher_out       = cipher_q;
  assign cipher_valid     = valid_q;
  assign busy             = (st != ST_IDLE);
  assign transformer_done = (st == ST_DONE);
  assign final_round_o    = (st == ST_ROUND)
                         && (cnt_q == LAST);

endmodule
